// File: rtl/sb_pkg.sv
// Shared types and constants for the two-master system-bus arbiter.
// Combinational helpers only; no latency.
// No backpressure here; flow control lives in sb_arbiter.
package sb_pkg;

    localparam int N_MASTERS   = 2;
    // Slave index field inside the master address
    localparam int SLV_IDX_MSB = 31;
    localparam int SLV_IDX_LSB = 24;
    localparam int SLV_IDX_W   = SLV_IDX_MSB - SLV_IDX_LSB + 1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACCESS   = 2'd1,
        ST_DONE_ERR = 2'd2
    } state_e;

    // One master's request fields, held stable by the master until its ready
    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wd;
    } mreq_t;

    // Round-robin pick between two masters: on a tie the master that was not
    // granted last wins, a lone requester always wins. Returns one-hot grant.
    function automatic logic [N_MASTERS-1:0] rr_pick(input logic [N_MASTERS-1:0] req,
                                                     input logic                 last);
        logic [N_MASTERS-1:0] g;
        g = '0;
        if (req == 2'b11) begin
            g = last ? 2'b01 : 2'b10;
        end else if (req[0]) begin
            g = 2'b01;
        end else if (req[1]) begin
            g = 2'b10;
        end
        return g;
    endfunction

endpackage

// File: rtl/sb_addr_decoder.sv
// Address decoder: slave index addr[31:24] -> one-hot select, mapped flag, cleared address.
// Purely combinational, zero latency.
// No backpressure; the caller decides when the select is used.
module sb_addr_decoder
    import sb_pkg::*;
#(
    parameter int N_SLAVES = 3
) (
    input  logic [31:0]         addr_i,
    output logic [N_SLAVES-1:0] sel_o,
    output logic                mapped_o,
    output logic [31:0]         addr_clr_o
);

    logic [SLV_IDX_W-1:0] idx;

    assign idx = addr_i[SLV_IDX_MSB:SLV_IDX_LSB];

    // Index compare and one-hot expansion; unmapped indices yield an all-zero select
    always_comb begin
        mapped_o   = (32'(idx) < 32'(N_SLAVES));
        addr_clr_o = addr_i;
        addr_clr_o[SLV_IDX_MSB:SLV_IDX_LSB] = '0;
        sel_o      = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            sel_o[i] = (idx == SLV_IDX_W'(i));
        end
    end

endmodule

// File: rtl/sb_arbiter.sv
// Two-master round-robin arbiter onto a decoded slave bus; optional ready timeout (SB_ARB_TIMEOUT_EN).
// Latency: one arbitration cycle plus slave wait states; zero-wait access completes 2 cycles after request.
// Backpressure: a master holds its request until its one-cycle m_ready_o pulse; slaves stall via s_ready_i.
module sb_arbiter
    import sb_pkg::*;
#(
    parameter int N_SLAVES = 3,
    parameter int TIMEOUT  = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [1:0]           m_req_i,
    input  logic [1:0]           m_we_i,
    input  logic [7:0]           m_be_i,
    input  logic [63:0]          m_addr_i,
    input  logic [63:0]          m_wd_i,
    output logic [63:0]          m_rd_o,
    output logic [1:0]           m_ready_o,
    output logic [N_SLAVES-1:0]  s_req_o,
    output logic                 s_we_o,
    output logic [3:0]           s_be_o,
    output logic [31:0]          s_addr_o,
    output logic [31:0]          s_wd_o,
    input  logic [31:0]          s_rd_i,
    input  logic                 s_ready_i,
    output logic                 err_o,
    output logic [1:0]           grant_o
);

    // Elaboration-time parameter sanity
    if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
        $error("sb_arbiter: TIMEOUT must be in 2..255");
    end
    if (N_SLAVES < 1 || N_SLAVES > 256) begin : g_bad_nslaves
        $error("sb_arbiter: N_SLAVES must be in 1..256");
    end

    state_e               state_q, state_d;
    logic [N_MASTERS-1:0] grant_q, grant_d;
    logic                 last_q,  last_d;   // index of the master granted last
`ifdef SB_ARB_TIMEOUT_EN
    logic [7:0]           cnt_q,   cnt_d;
`endif

    logic                 gidx;
    mreq_t                cur;
    logic [N_SLAVES-1:0]  dec_sel;
    logic                 dec_mapped;
    logic [31:0]          dec_addr;

    assign gidx    = grant_q[1];
    assign grant_o = grant_q;

    // Select the granted master's request fields (master 0 when nothing is granted)
    always_comb begin
        cur      = '0;
        cur.we   = m_we_i[gidx];
        cur.be   = gidx ? m_be_i[7:4]     : m_be_i[3:0];
        cur.addr = gidx ? m_addr_i[63:32] : m_addr_i[31:0];
        cur.wd   = gidx ? m_wd_i[63:32]   : m_wd_i[31:0];
    end

    sb_addr_decoder #(
        .N_SLAVES (N_SLAVES)
    ) u_dec (
        .addr_i     (cur.addr),
        .sel_o      (dec_sel),
        .mapped_o   (dec_mapped),
        .addr_clr_o (dec_addr)
    );

    // Bus outputs: slave side forwarded only in ACCESS, master completion on ready or error
    always_comb begin
        s_req_o   = '0;
        s_we_o    = 1'b0;
        s_be_o    = '0;
        s_addr_o  = '0;
        s_wd_o    = '0;
        m_ready_o = '0;
        m_rd_o    = '0;
        err_o     = 1'b0;
        case (state_q)
            ST_ACCESS: begin
                s_req_o  = dec_mapped ? dec_sel : '0;
                s_we_o   = cur.we;
                s_be_o   = cur.be;
                s_addr_o = dec_addr;
                s_wd_o   = cur.wd;
                if (dec_mapped && s_ready_i) begin
                    m_ready_o[gidx] = 1'b1;
                    if (gidx) begin
                        m_rd_o[63:32] = s_rd_i;
                    end else begin
                        m_rd_o[31:0]  = s_rd_i;
                    end
                end
            end
            ST_DONE_ERR: begin
                // Read data stays zero on an error completion
                m_ready_o[gidx] = 1'b1;
                err_o           = 1'b1;
            end
            default: ;
        endcase
    end

    // Next-state: arbitration in IDLE, completion / error / timeout in ACCESS
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
`ifdef SB_ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (|m_req_i) begin
                    grant_d = rr_pick(m_req_i, last_q);
                    state_d = ST_ACCESS;
`ifdef SB_ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            ST_ACCESS: begin
                if (!dec_mapped) begin
                    state_d = ST_DONE_ERR;
                end else if (s_ready_i) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    last_d  = gidx;
                end else begin
`ifdef SB_ARB_TIMEOUT_EN
                    // Give up once the wait count reaches TIMEOUT-1
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_d == 8'(TIMEOUT - 1)) begin
                        state_d = ST_DONE_ERR;
                    end
`endif
                end
            end
            ST_DONE_ERR: begin
                state_d = ST_IDLE;
                grant_d = '0;
                last_d  = gidx;
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State registers; reset leaves master 1 as last-granted so master 0 wins first
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            last_q  <= 1'b1;
`ifdef SB_ARB_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
`ifdef SB_ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_sb_arbiter.sv
// Self-checking bench for sb_arbiter: vector table, reset, back-to-back and timeout sequences.
// Completions are scored against per-master expectation queues filled when stimulus is driven.
// Slave model answers with configurable wait states.
module tb_sb_arbiter;

    localparam int NS  = 3;
    localparam int TO  = 16;
    localparam logic [31:0] KEY = 32'h1234_567C;   // slave read data = cleared addr ^ KEY

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic [1:0]   m_req_i, m_we_i;
    logic [7:0]   m_be_i;
    logic [63:0]  m_addr_i, m_wd_i;
    logic [63:0]  m_rd_o;
    logic [1:0]   m_ready_o;
    logic [NS-1:0] s_req_o;
    logic         s_we_o;
    logic [3:0]   s_be_o;
    logic [31:0]  s_addr_o, s_wd_o;
    logic [31:0]  s_rd_i;
    logic         s_ready_i;
    logic         err_o;
    logic [1:0]   grant_o;

    sb_arbiter #(.N_SLAVES(NS), .TIMEOUT(TO)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .m_req_i   (m_req_i),
        .m_we_i    (m_we_i),
        .m_be_i    (m_be_i),
        .m_addr_i  (m_addr_i),
        .m_wd_i    (m_wd_i),
        .m_rd_o    (m_rd_o),
        .m_ready_o (m_ready_o),
        .s_req_o   (s_req_o),
        .s_we_o    (s_we_o),
        .s_be_o    (s_be_o),
        .s_addr_o  (s_addr_o),
        .s_wd_o    (s_wd_o),
        .s_rd_i    (s_rd_i),
        .s_ready_i (s_ready_i),
        .err_o     (err_o),
        .grant_o   (grant_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [31:0] rd;
        logic        err;
    } exp_t;

    typedef struct {
        int          m;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wd;
        int          wait_n;
        logic [2:0]  exp_sreq;
        logic [31:0] exp_saddr;
        logic        exp_err;
        logic [31:0] exp_rd;
        int          exp_lat;
    } vec_t;

    exp_t q0[$];
    exp_t q1[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   slave_wait = 0;
    int   wcnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input int m, input logic [31:0] rd, input logic err);
        exp_t e;
        e.rd  = rd;
        e.err = err;
        if (m == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic set_master(input int m, input logic we, input logic [3:0] be,
                              input logic [31:0] addr, input logic [31:0] wd);
        m_we_i[m]          = we;
        m_be_i[m*4 +: 4]   = be;
        m_addr_i[m*32 +: 32] = addr;
        m_wd_i[m*32 +: 32] = wd;
    endtask

    // Slave model: decides ready shortly after each rising edge
    initial begin
        s_ready_i = 1'b0;
        s_rd_i    = '0;
        forever begin
            @(posedge clk_i);
            #2;
            if (s_req_o != '0) begin
                if (wcnt >= slave_wait) begin
                    s_ready_i = 1'b1;
                    s_rd_i    = s_addr_o ^ KEY;
                end else begin
                    s_ready_i = 1'b0;
                    s_rd_i    = '0;
                end
                wcnt++;
            end else begin
                s_ready_i = 1'b0;
                s_rd_i    = '0;
                wcnt      = 0;
            end
        end
    end

    // Completion monitor: every ready pulse is scored against the queued expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (!rst_i) begin
                for (int m = 0; m < 2; m++) begin
                    if (m_ready_o[m]) begin
                        if ((m == 0 ? q0.size() : q1.size()) == 0) begin
                            chk($sformatf("unexpected_ready_m%0d", m), 64'(m_ready_o), 64'd0);
                        end else begin
                            e = (m == 0) ? q0.pop_front() : q1.pop_front();
                            chk($sformatf("rd_m%0d", m), 64'(m_rd_o[m*32 +: 32]), 64'(e.rd));
                            chk($sformatf("err_m%0d", m), 64'(err_o), 64'(e.err));
                        end
                    end
                end
                if (err_o && m_ready_o == 2'b00) chk("err_without_ready", 64'(err_o), 64'd0);
            end
        end
    end

    task automatic run_vec(input vec_t v, input string tag);
        int cyc;
        bit seen;
        slave_wait = v.wait_n;
        @(posedge clk_i);
        #1;
        set_master(v.m, v.we, v.be, v.addr, v.wd);
        m_req_i[v.m] = 1'b1;
        push_exp(v.m, v.exp_rd, v.exp_err);
        seen = 0;
        cyc  = 0;
        while (!seen && cyc < 100) begin
            @(posedge clk_i);
            cyc++;
            @(negedge clk_i);
            if (cyc == 1) begin
                chk({tag, "_grant"}, 64'(grant_o), 64'(v.m == 0 ? 2'b01 : 2'b10));
                chk({tag, "_sreq"},  64'(s_req_o), 64'(v.exp_sreq));
                chk({tag, "_saddr"}, 64'(s_addr_o), 64'(v.exp_saddr));
                chk({tag, "_swe"},   64'(s_we_o), 64'(v.we));
                chk({tag, "_sbe"},   64'(s_be_o), 64'(v.be));
                chk({tag, "_swd"},   64'(s_wd_o), 64'(v.wd));
            end
            if (m_ready_o[v.m]) seen = 1;
        end
        chk({tag, "_ready_seen"}, 64'(seen), 64'd1);
        chk({tag, "_latency"}, 64'(cyc + 1), 64'(v.exp_lat));
        @(posedge clk_i);
        #1;
        m_req_i[v.m] = 1'b0;
    endtask

    vec_t vecs[7];

    initial begin
        int   nrdy[2];
        int   lastc[2];
        int   cyc;
        int   cnt;
        logic [1:0] prevg;
        bit   seen;

        vecs[0] = '{0, 1'b0, 4'hF, 32'h0100_0004, 32'h0,         0, 3'b010, 32'h0000_0004, 1'b0, 32'h1234_5678, 2};
        vecs[1] = '{1, 1'b1, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF, 0, 3'b001, 32'h0000_0010, 1'b0, 32'h1234_566C, 2};
        vecs[2] = '{1, 1'b1, 4'h3, 32'h0500_0000, 32'hCAFE_0001, 0, 3'b000, 32'h0000_0000, 1'b1, 32'h0,         3};
        vecs[3] = '{0, 1'b0, 4'hF, 32'h02AB_CDEF, 32'h0,         3, 3'b100, 32'h00AB_CDEF, 1'b0, 32'h129F_9B93, 5};
        vecs[4] = '{0, 1'b0, 4'h1, 32'h0300_0000, 32'h0,         0, 3'b000, 32'h0000_0000, 1'b1, 32'h0,         3};
        vecs[5] = '{1, 1'b0, 4'hF, 32'hFF00_0008, 32'h0,         0, 3'b000, 32'h0000_0008, 1'b1, 32'h0,         3};
        vecs[6] = '{1, 1'b0, 4'hC, 32'h0200_0100, 32'h5555_AAAA, 1, 3'b100, 32'h0000_0100, 1'b0, 32'h1234_577C, 3};

        rst_i    = 1'b1;
        m_req_i  = '0;
        m_we_i   = '0;
        m_be_i   = '0;
        m_addr_i = '0;
        m_wd_i   = '0;

        // Reset state
        repeat (2) @(negedge clk_i);
        chk("rst_ready", 64'(m_ready_o), 64'd0);
        chk("rst_rd",    m_rd_o, 64'd0);
        chk("rst_sreq",  64'(s_req_o), 64'd0);
        chk("rst_err",   64'(err_o), 64'd0);
        chk("rst_grant", 64'(grant_o), 64'd0);
        chk("rst_saddr", 64'(s_addr_o), 64'd0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        // Single-master vector table
        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset in the 3rd wait cycle of an M0 access, with M1 pending behind it
        run_vec(vecs[0], "pre_rst");
        slave_wait = 50;
        @(posedge clk_i);
        #1;
        set_master(0, 1'b0, 4'hF, 32'h0100_0008, 32'h0);
        m_req_i[0] = 1'b1;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        #1;
        rst_i = 1'b1;
        #1;
        chk("arst_ready", 64'(m_ready_o), 64'd0);
        chk("arst_sreq",  64'(s_req_o), 64'd0);
        chk("arst_grant", 64'(grant_o), 64'd0);
        chk("arst_saddr", 64'(s_addr_o), 64'd0);
        set_master(1, 1'b0, 4'hF, 32'h0000_0044, 32'h0);
        m_req_i[1] = 1'b1;
        slave_wait = 0;
        push_exp(0, 32'h1234_5674, 1'b0);
        push_exp(1, 32'h1234_5638, 1'b0);
        @(negedge clk_i);
        #1;
        rst_i = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        chk("post_rst_m0_first", 64'(grant_o), 64'(2'b01));
        @(posedge clk_i);
        #1;
        m_req_i[0] = 1'b0;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk_i);
            if (m_ready_o[1]) seen = 1;
        end
        chk("post_rst_m1_served", 64'(seen), 64'd1);
        @(posedge clk_i);
        #1;
        m_req_i[1] = 1'b0;

        // Both masters requesting continuously against a zero-wait slave
        slave_wait = 0;
        @(posedge clk_i);
        #1;
        set_master(0, 1'b0, 4'hF, 32'h0000_0020, 32'h0);
        set_master(1, 1'b0, 4'hF, 32'h0100_0040, 32'h0);
        m_req_i = 2'b11;
        for (int k = 0; k < 4; k++) begin
            push_exp(0, 32'h1234_565C, 1'b0);
            push_exp(1, 32'h1234_563C, 1'b0);
        end
        nrdy  = '{0, 0};
        lastc = '{0, 0};
        prevg = 2'b00;
        cyc   = 0;
        while ((nrdy[0] < 4 || nrdy[1] < 4) && cyc < 60) begin
            @(posedge clk_i);
            cyc++;
            #1;
            for (int m = 0; m < 2; m++) if (nrdy[m] >= 4) m_req_i[m] = 1'b0;
            @(negedge clk_i);
            if (grant_o != 2'b00) begin
                if (prevg == 2'b00) chk("b2b_first_grant", 64'(grant_o), 64'(2'b01));
                else chk("b2b_alternate", 64'(grant_o), 64'(prevg == 2'b01 ? 2'b10 : 2'b01));
                prevg = grant_o;
            end
            for (int m = 0; m < 2; m++) begin
                if (m_ready_o[m]) begin
                    if (nrdy[m] > 0) chk($sformatf("b2b_period_m%0d", m), 64'(cyc - lastc[m]), 64'd4);
                    lastc[m] = cyc;
                    nrdy[m]++;
                end
            end
        end
        chk("b2b_count_m0", 64'(nrdy[0]), 64'd4);
        chk("b2b_count_m1", 64'(nrdy[1]), 64'd4);
        @(posedge clk_i);
        #1;
        m_req_i = 2'b00;

        // Slave that never answers
`ifdef SB_ARB_TIMEOUT_EN
        begin
            vec_t tv;
            tv = '{0, 1'b0, 4'hF, 32'h0100_0000, 32'h0, 1000000, 3'b010, 32'h0, 1'b1, 32'h0, TO + 1};
            run_vec(tv, "timeout");
        end
`else
        slave_wait = 1000000;
        @(posedge clk_i);
        #1;
        set_master(0, 1'b0, 4'hF, 32'h0100_0000, 32'h0);
        m_req_i[0] = 1'b1;
        cnt = 0;
        repeat (1000) begin
            @(negedge clk_i);
            if (m_ready_o != 2'b00 || err_o) cnt++;
        end
        chk("no_timeout_readies", 64'(cnt), 64'd0);
        chk("no_timeout_still_granted", 64'(grant_o), 64'(2'b01));
        m_req_i[0] = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        slave_wait = 0;
`endif

        repeat (3) @(negedge clk_i);
        chk("q0_drained", 64'(q0.size()), 64'd0);
        chk("q1_drained", 64'(q1.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
